// File: rtl/wb_scoreboard_pkg.sv
// Shared constants, types and the saturating step function for the
// issue-side register scoreboard.
package wb_scoreboard_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 4;
  localparam int CNT_W    = 2;
  localparam int TOT_W    = 4;

  // CPSR flags ride on one extra counter just past the architectural regs.
  localparam int FLAG_IDX = NUM_REGS;
  localparam int NUM_CNT  = NUM_REGS + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [TOT_W-1:0] tot_t;

  // inc_ok/dec_ok mark an issue/retire that really took effect; a held
  // inc+dec pair reports both so the total count nets to zero.
  typedef struct packed {
    cnt_t nxt;
    logic inc_ok;
    logic dec_ok;
    logic ovf;
    logic unf;
  } step_t;

  function automatic step_t sat_step(cnt_t cnt, logic inc, logic dec);
    step_t s;
    s.nxt    = cnt;
    s.inc_ok = 1'b0;
    s.dec_ok = 1'b0;
    s.ovf    = 1'b0;
    s.unf    = 1'b0;
    case ({inc, dec})
      2'b10: if (cnt == '1) s.ovf = 1'b1;
             else begin s.nxt = cnt + 1'b1; s.inc_ok = 1'b1; end
      2'b01: if (cnt == '0) s.unf = 1'b1;
             else begin s.nxt = cnt - 1'b1; s.dec_ok = 1'b1; end
      2'b11: begin s.inc_ok = 1'b1; s.dec_ok = 1'b1; end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wb_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle: issue, sources, retire, status.
interface wb_scoreboard_if;
  import wb_scoreboard_pkg::*;

  logic     issue_valid;
  logic     issue_wb_en;
  reg_idx_t issue_dest;
  logic     issue_s;
  reg_idx_t src1;
  reg_idx_t src2;
  logic     two_src;
  logic     need_flags;
  logic     retire_valid;
  logic     retire_wb_en;
  reg_idx_t retire_dest;
  logic     retire_s;
  logic     hazard_detected;
  logic     issue_accept;
  tot_t     in_flight;
  logic     overflow_err;
  logic     underflow_err;

  modport master (
    output issue_valid, issue_wb_en, issue_dest, issue_s,
           src1, src2, two_src, need_flags,
           retire_valid, retire_wb_en, retire_dest, retire_s,
    input  hazard_detected, issue_accept, in_flight,
           overflow_err, underflow_err
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_dest, issue_s,
           src1, src2, two_src, need_flags,
           retire_valid, retire_wb_en, retire_dest, retire_s,
    output hazard_detected, issue_accept, in_flight,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/wb_scoreboard_sb_counter.sv
// One pending-write counter (register or flags) with sticky saturation errors.
module sb_counter
  import wb_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic pend,
  output logic inc_ok,
  output logic dec_ok,
  output logic ovf_err,
  output logic unf_err
);

  cnt_t  cnt;
  step_t st;

  assign st     = sat_step(cnt, inc, dec);
  // A retire this cycle retires the last write early (write-before-read).
  assign pend   = (cnt > {{(CNT_W-1){1'b0}}, dec});
  assign inc_ok = st.inc_ok;
  assign dec_ok = st.dec_ok;

  // Count and sticky errors; clear beats any same-cycle inc/dec.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      cnt     <= st.nxt;
      ovf_err <= ovf_err | st.ovf;
      unf_err <= unf_err | st.unf;
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Issue-side scoreboard: tracks in-flight register/CPSR writes between the
// ID->EXE issue point and WB, and requests a stall on read-after-write.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  wb_scoreboard_if.slave  sb
);

  logic [NUM_CNT-1:0] inc, dec, pend, inc_ok, dec_ok, ovf_v, unf_v;
  logic               hazard, accept;
  logic [1:0]         n_up, n_dn;
  tot_t               in_flight_q;
  int                 nxt_if;

  // Per-counter issue/retire strobes; issue is only recorded when accepted.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = accept & sb.issue_wb_en & (sb.issue_dest == REG_W'(r));
      dec[r] = sb.retire_valid & sb.retire_wb_en & (sb.retire_dest == REG_W'(r));
    end
    inc[FLAG_IDX] = accept & sb.issue_s;
    dec[FLAG_IDX] = sb.retire_valid & sb.retire_s;
  end

  for (genvar r = 0; r < NUM_CNT; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .inc     (inc[r]),
      .dec     (dec[r]),
      .pend    (pend[r]),
      .inc_ok  (inc_ok[r]),
      .dec_ok  (dec_ok[r]),
      .ovf_err (ovf_v[r]),
      .unf_err (unf_v[r])
    );
  end

  // Stall depends only on state and retire inputs, never on issue_*.
  assign hazard = pend[sb.src1]
                | (sb.two_src & pend[sb.src2])
                | (sb.need_flags & pend[FLAG_IDX]);
  // Gated by rst_n so accept also reads 0 while reset is held.
  assign accept = sb.issue_valid & ~hazard & rst_n;

  // At most one register plus flags move in each direction per cycle.
  assign n_up = {1'b0, |inc_ok[NUM_REGS-1:0]} + {1'b0, inc_ok[FLAG_IDX]};
  assign n_dn = {1'b0, |dec_ok[NUM_REGS-1:0]} + {1'b0, dec_ok[FLAG_IDX]};

  // Saturating next value of the total in-flight count.
  always_comb begin
    nxt_if = int'(in_flight_q) + int'(n_up) - int'(n_dn);
    if (nxt_if < 0)                nxt_if = 0;
    if (nxt_if > (1 << TOT_W) - 1) nxt_if = (1 << TOT_W) - 1;
  end

  // Total in-flight register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     in_flight_q <= '0;
    else if (clear) in_flight_q <= '0;
    else            in_flight_q <= TOT_W'(nxt_if);
  end

  assign sb.hazard_detected = hazard;
  assign sb.issue_accept    = accept;
  assign sb.in_flight       = in_flight_q;
  assign sb.overflow_err    = |ovf_v;
  assign sb.underflow_err   = |unf_v;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed scoreboard bench: stimulus pushes the expected outputs for each
// cycle, a negedge monitor pops and compares.
module tb_wb_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  wb_scoreboard_if sb ();

  wb_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       h;
    logic       a;
    logic [3:0] f;
    logic       o;
    logic       u;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest entry.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.nm, "hazard", int'(sb.hazard_detected), int'(e.h));
      cmp(e.nm, "accept", int'(sb.issue_accept),    int'(e.a));
      cmp(e.nm, "in_flight", int'(sb.in_flight),    int'(e.f));
      cmp(e.nm, "ovf",    int'(sb.overflow_err),    int'(e.o));
      cmp(e.nm, "unf",    int'(sb.underflow_err),   int'(e.u));
    end
  end

  task automatic idle();
    sb.issue_valid = 0; sb.issue_wb_en = 0; sb.issue_dest = 0; sb.issue_s = 0;
    sb.src1 = 0; sb.src2 = 0; sb.two_src = 0; sb.need_flags = 0;
    sb.retire_valid = 0; sb.retire_wb_en = 0; sb.retire_dest = 0; sb.retire_s = 0;
    clear = 0;
  endtask

  task automatic iss(input int d, input logic wb, input logic s);
    sb.issue_valid = 1; sb.issue_wb_en = wb; sb.issue_dest = 4'(d); sb.issue_s = s;
  endtask

  task automatic ret(input int d, input logic wb, input logic s);
    sb.retire_valid = 1; sb.retire_wb_en = wb; sb.retire_dest = 4'(d); sb.retire_s = s;
  endtask

  task automatic src(input int s1, input int s2, input logic two, input logic nf);
    sb.src1 = 4'(s1); sb.src2 = 4'(s2); sb.two_src = two; sb.need_flags = nf;
  endtask

  // Queue expectation for the current cycle, then advance to the next one.
  task automatic chk(input logic h, input logic a, input int f,
                     input logic o, input logic u, input string nm);
    exp_t e;
    e.h = h; e.a = a; e.f = 4'(f); e.o = o; e.u = u; e.nm = nm;
    q.push_back(e);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    chk(0, 0, 0, 0, 0, "reset");
    rst_n = 1;

    // 1: issue R3, then reading R3 stalls
    iss(3, 1, 0);                          chk(0, 1, 0, 0, 0, "iss_r3");
    iss(9, 1, 0); src(3, 0, 0, 0);         chk(1, 0, 1, 0, 0, "raw_r3");
    // 2: retire R3 while reading it
    ret(3, 1, 0); src(3, 0, 0, 0);         chk(0, 0, 1, 0, 0, "wbr_r3");
    iss(0, 0, 0); src(3, 0, 0, 0);         chk(0, 1, 0, 0, 0, "store_nop");
    // 3: fill R5, overflow on fourth issue
    iss(5, 1, 0);                          chk(0, 1, 0, 0, 0, "r5_a");
    iss(5, 1, 0);                          chk(0, 1, 1, 0, 0, "r5_b");
    iss(5, 1, 0);                          chk(0, 1, 2, 0, 0, "r5_c");
    iss(5, 1, 0);                          chk(0, 1, 3, 0, 0, "r5_ovf");
    src(0, 5, 1, 0);                       chk(1, 0, 3, 1, 0, "src2_r5");
    src(0, 5, 0, 0);                       chk(0, 0, 3, 1, 0, "src2_off");
    ret(5, 1, 0); src(0, 5, 1, 0);         chk(1, 0, 3, 1, 0, "r5_ret1");
    ret(5, 1, 0); src(0, 5, 1, 0);         chk(1, 0, 2, 1, 0, "r5_ret2");
    ret(5, 1, 0); src(0, 5, 1, 0);         chk(0, 0, 1, 1, 0, "r5_ret3");
    src(0, 5, 1, 0);                       chk(0, 0, 0, 1, 0, "r5_empty");
    // 4: CMP sets flags, MOVEQ waits for flag retire
    iss(0, 0, 1);                          chk(0, 1, 0, 1, 0, "cmp_s");
    iss(6, 1, 0); src(0, 0, 0, 1);         chk(1, 0, 1, 1, 0, "moveq_a");
    iss(6, 1, 0); src(0, 0, 0, 1);         chk(1, 0, 1, 1, 0, "moveq_b");
    iss(6, 1, 0); src(0, 0, 0, 1); ret(0, 0, 1); chk(0, 1, 1, 1, 0, "flag_ret");
    src(3, 5, 1, 1);                       chk(0, 0, 1, 1, 0, "regs_clean");
    ret(6, 1, 0); src(6, 0, 0, 0);         chk(0, 0, 1, 1, 0, "r6_wbr");
    // 5: same-cycle issue/retire of R7, then underflow on R2
    iss(7, 1, 0);                          chk(0, 1, 0, 1, 0, "iss_r7");
    iss(7, 1, 0); ret(7, 1, 0);            chk(0, 1, 1, 1, 0, "r7_both");
    src(7, 0, 0, 0);                       chk(1, 0, 1, 1, 0, "r7_held");
    ret(2, 1, 0); src(7, 0, 0, 0);         chk(1, 0, 1, 1, 0, "r2_unf");
    src(2, 0, 0, 0);                       chk(0, 0, 1, 1, 1, "r2_zero");
    // 6: async reset mid-cycle
    iss(1, 1, 0);                          chk(0, 1, 1, 1, 1, "iss_r1");
    iss(4, 1, 1);                          chk(0, 1, 2, 1, 1, "iss_r4f");
    src(1, 4, 1, 1);                       chk(1, 0, 4, 1, 1, "pend_all");
    rst_n = 0; iss(1, 1, 0); src(1, 4, 1, 1); chk(0, 0, 0, 0, 0, "async_rst");
    rst_n = 1; src(1, 7, 1, 1);            chk(0, 0, 0, 0, 0, "post_rst");
    // 6b: synchronous clear
    iss(1, 1, 1);                          chk(0, 1, 0, 0, 0, "c_iss_r1f");
    iss(4, 1, 0);                          chk(0, 1, 2, 0, 0, "c_iss_r4");
    ret(9, 1, 0); src(1, 0, 0, 1);         chk(1, 0, 3, 0, 0, "c_unf");
    clear = 1; iss(4, 1, 0); src(1, 0, 0, 1); chk(1, 0, 3, 0, 1, "clear");
    src(1, 4, 1, 1);                       chk(0, 0, 0, 0, 0, "post_clear");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
